// File: rtl/spi_port_arbiter.sv
// spi_port_arbiter: shares the SPI gateway bus between NPORTS byte-stream ports plus a status register
module spi_port_arbiter #(
    parameter int         NPORTS    = 4,
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter logic [7:0] STAT_ADDR = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            addr,
    input  logic                  sel,
    input  logic [7:0]            rxd,
    input  logic                  rxe,
    input  logic                  txe,
    output logic [7:0]            txd,
    output logic [NPORTS-1:0]     port_sel,
    output logic [NPORTS-1:0]     port_rxe,
    output logic [NPORTS-1:0]     port_txe,
    output logic [7:0]            port_rxd,
    input  logic [8*NPORTS-1:0]   port_txd,
    output logic [7:0]            byte_idx,
    input  logic [NPORTS-1:0]     attn
);
    typedef enum logic [1:0] {IDLE, DECODE, ACTIVE} state_t;
    state_t state, state_nx;
    logic armed, txe_d, tx_req, sel_stat, sel_none, start, done, tx_rise, rx_acc, hit;
    logic [2:0] sel_idx;
    logic [7:0] off, err_cnt, stat_byte;
    logic [NPORTS-1:0] pending, snap;

    always_comb begin
        start = state == IDLE && sel && armed;
        done = state == ACTIVE && !sel;
        state_nx = start ? DECODE : state == DECODE ? ACTIVE : done ? IDLE : state;
        off = addr - BASE_ADDR;
        hit = off < 8'(NPORTS);
        tx_rise = txe && !txe_d && state != IDLE;
        rx_acc = rxe && state == ACTIVE && sel;
        stat_byte = byte_idx == 8'd0 ? 8'(pending) : byte_idx == 8'd1 ? err_cnt : 8'h00;
        txd = state == IDLE || sel_none ? 8'hFF : sel_stat ? stat_byte : port_txd[8*sel_idx +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed    <= 1'b0;
            txe_d    <= 1'b0;
            tx_req   <= 1'b0;
            port_sel <= '0;
            port_rxe <= '0;
            port_txe <= '0;
            port_rxd <= '0;
            byte_idx <= '0;
            sel_idx  <= '0;
            sel_stat <= 1'b0;
            sel_none <= 1'b0;
            err_cnt  <= '0;
            pending  <= '0;
            snap     <= '0;
        end else begin
            armed    <= armed || !sel;
            txe_d    <= txe;
            tx_req   <= tx_rise;
            port_rxe <= rx_acc ? port_sel : '0;
            port_txe <= tx_rise ? port_sel : '0;
            if (rx_acc && |port_sel) port_rxd <= rxd;
            pending  <= (done && sel_stat ? pending & ~snap : pending) | attn;
            // a bit re-raised after being reported drops out of the snapshot so the clear cannot lose it
            snap     <= start || done ? '0 :
                        tx_req && sel_stat && byte_idx == 8'd0 ? pending & ~attn : snap & ~attn;
            if (start) begin
                port_sel <= hit ? NPORTS'(1) << off[2:0] : '0;
                sel_idx  <= off[2:0];
                sel_stat <= addr == STAT_ADDR;
                sel_none <= !hit && addr != STAT_ADDR;
            end else if (done) begin
                port_sel <= '0;
                sel_idx  <= '0;
                sel_stat <= 1'b0;
                sel_none <= 1'b0;
                byte_idx <= '0;
                if (sel_none && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (rx_acc && byte_idx != 8'hFF) begin
                byte_idx <= byte_idx + 8'd1;
            end
        end
    end
endmodule
